fir_tap_sequencer: RTL

- Controller for the sample delay-line RAM of the FIR filter.
- Accepts one input sample at a time and writes it into a circular buffer. The buffer is a dual-port RAM with one write port and a synchronous read port with 1-cycle read latency.
- Replays the newest NUM_TAPS samples, newest first, to the MAC datapath, each tagged with its coefficient index.
- Zero-fills the RAM after reset so the filter starts from a clean history.

---
 rtl/fir_tap_sequencer_if.sv | 48 ++++
 rtl/fir_tap_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fir_tap_sequencer_if                                        |
// | Desc   : Sample handshake, delay-line RAM and tap-stream bundle for  |
// |          fir_tap_sequencer. master = sequencer side, slave = the     |
// |          environment (sample source, RAM, MAC datapath).             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface fir_tap_sequencer_if #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5
) ();
  // sample intake
  logic                 i_sample_valid;
  logic [DATA_SIZE-1:0] i_sample;
  logic                 o_sample_ready;
  // delay-line RAM
  logic                 o_mem_wen;
  logic [ADDR_SIZE-1:0] o_mem_waddr;
  logic [DATA_SIZE-1:0] o_mem_wdata;
  logic [ADDR_SIZE-1:0] o_mem_raddr;
  logic [DATA_SIZE-1:0] i_mem_rdata;
  // tap stream towards the MAC
  logic                 o_tap_valid;
  logic [DATA_SIZE-1:0] o_tap_data;
  logic [ADDR_SIZE-1:0] o_coef_idx;
  logic                 o_tap_first;
  logic                 o_tap_last;
  // status
  logic                 o_busy;
  logic                 o_overrun;
  logic                 i_clr_overrun;

  modport master (
    input  i_sample_valid, i_sample, i_mem_rdata, i_clr_overrun,
    output o_sample_ready, o_mem_wen, o_mem_waddr, o_mem_wdata, o_mem_raddr,
           o_tap_valid, o_tap_data, o_coef_idx, o_tap_first, o_tap_last,
           o_busy, o_overrun
  );

  modport slave (
    output i_sample_valid, i_sample, i_mem_rdata, i_clr_overrun,
    input  o_sample_ready, o_mem_wen, o_mem_waddr, o_mem_wdata, o_mem_raddr,
           o_tap_valid, o_tap_data, o_coef_idx, o_tap_first, o_tap_last,
           o_busy, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fir_tap_sequencer                                           |
// | Desc   : Circular delay-line controller for the FIR filter. Zeroes   |
// |          the sample RAM after reset, writes each accepted sample and |
// |          replays the newest NUM_TAPS samples (newest first) with     |
// |          their coefficient index to the MAC datapath.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fir_tap_sequencer #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5,
  parameter int NUM_TAPS  = 32
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  fir_tap_sequencer_if.master bus
);

  localparam int                   c_depth_int = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]   c_depth     = (ADDR_SIZE+1)'(c_depth_int);
  localparam logic [ADDR_SIZE-1:0] c_last_k    = ADDR_SIZE'(NUM_TAPS - 1);
  localparam logic [ADDR_SIZE-1:0] c_addr_one  = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   c_init_one  = (ADDR_SIZE+1)'(1);

  // A filter longer than the RAM cannot be replayed from it.
  if (NUM_TAPS < 1 || NUM_TAPS > c_depth_int) begin : g_bad_num_taps
    $error("fir_tap_sequencer: NUM_TAPS must be within 1..2**ADDR_SIZE");
  end

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [ADDR_SIZE:0]   r_init_cnt,  w_init_cnt_nxt;
  logic [ADDR_SIZE-1:0] r_wptr,      w_wptr_nxt;
  logic [ADDR_SIZE-1:0] r_base,      w_base_nxt;     // W of the sample being replayed
  logic [ADDR_SIZE-1:0] r_rd_cnt,    w_rd_cnt_nxt;   // k of the next address to issue
  logic                 r_addr_vld,  w_addr_vld_nxt; // raddr in flight this cycle
  logic [ADDR_SIZE-1:0] r_addr_k,    w_addr_k_nxt;   // k belonging to that raddr

  logic                 r_mem_wen,   w_mem_wen_nxt;
  logic [ADDR_SIZE-1:0] r_mem_waddr, w_mem_waddr_nxt;
  logic [DATA_SIZE-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [ADDR_SIZE-1:0] r_mem_raddr, w_mem_raddr_nxt;
  logic                 r_tap_valid, w_tap_valid_nxt;
  logic [ADDR_SIZE-1:0] r_coef_idx,  w_coef_idx_nxt;
  logic                 r_tap_first, w_tap_first_nxt;
  logic                 r_tap_last,  w_tap_last_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic                 r_ready,     w_ready_nxt;
  logic                 r_overrun,   w_overrun_nxt;

  logic                 w_accept;

  // Ready is only ever high in IDLE, so this alone qualifies an accept.
  assign w_accept = bus.i_sample_valid & r_ready;

  // Next-state, RAM command and tap-tag decode for the coming edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_wptr_nxt      = r_wptr;
    w_base_nxt      = r_base;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_addr_vld_nxt  = 1'b0;
    w_addr_k_nxt    = r_addr_k;
    w_mem_wen_nxt   = 1'b0;
    w_mem_waddr_nxt = r_mem_waddr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_raddr_nxt = r_mem_raddr;

    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == c_depth) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_mem_wen_nxt   = 1'b1;
          w_mem_waddr_nxt = r_init_cnt[ADDR_SIZE-1:0];
          w_mem_wdata_nxt = '0;
          w_init_cnt_nxt  = r_init_cnt + c_init_one;
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt     = ST_READ;
          w_mem_wen_nxt   = 1'b1;
          w_mem_waddr_nxt = r_wptr;
          w_mem_wdata_nxt = bus.i_sample;
          w_wptr_nxt      = r_wptr + c_addr_one;
          w_base_nxt      = r_wptr;
          w_rd_cnt_nxt    = '0;
        end
      end
      ST_READ: begin
        // The write of W lands on this same edge, so the k=0 read that the
        // RAM samples one edge later already sees the new sample.
        w_mem_raddr_nxt = r_base - r_rd_cnt;
        w_addr_vld_nxt  = 1'b1;
        w_addr_k_nxt    = r_rd_cnt;
        w_rd_cnt_nxt    = r_rd_cnt + c_addr_one;
        if (r_rd_cnt == c_last_k) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase

    // Tap tags trail the read address by the RAM's one-cycle latency.
    w_tap_valid_nxt = r_addr_vld;
    w_coef_idx_nxt  = r_addr_k;
    w_tap_first_nxt = r_addr_vld & (r_addr_k == '0);
    w_tap_last_nxt  = r_addr_vld & (r_addr_k == c_last_k);

    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_ready_nxt     = (w_state_nxt == ST_IDLE);
    // A drop on the same edge as a clear must stay visible.
    w_overrun_nxt   = (bus.i_sample_valid & ~r_ready) | (r_overrun & ~bus.i_clr_overrun);
  end

  // State and registered outputs; reset restarts the zero-fill sweep.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_wptr      <= '0;
      r_base      <= '0;
      r_rd_cnt    <= '0;
      r_addr_vld  <= 1'b0;
      r_addr_k    <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_raddr <= '0;
      r_tap_valid <= 1'b0;
      r_coef_idx  <= '0;
      r_tap_first <= 1'b0;
      r_tap_last  <= 1'b0;
      r_busy      <= 1'b1;
      r_ready     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_wptr      <= w_wptr_nxt;
      r_base      <= w_base_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_addr_vld  <= w_addr_vld_nxt;
      r_addr_k    <= w_addr_k_nxt;
      r_mem_wen   <= w_mem_wen_nxt;
      r_mem_waddr <= w_mem_waddr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_raddr <= w_mem_raddr_nxt;
      r_tap_valid <= w_tap_valid_nxt;
      r_coef_idx  <= w_coef_idx_nxt;
      r_tap_first <= w_tap_first_nxt;
      r_tap_last  <= w_tap_last_nxt;
      r_busy      <= w_busy_nxt;
      r_ready     <= w_ready_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.o_sample_ready = r_ready;
  assign bus.o_mem_wen      = r_mem_wen;
  assign bus.o_mem_waddr    = r_mem_waddr;
  assign bus.o_mem_wdata    = r_mem_wdata;
  assign bus.o_mem_raddr    = r_mem_raddr;
  assign bus.o_tap_valid    = r_tap_valid;
  assign bus.o_tap_data     = bus.i_mem_rdata;
  assign bus.o_coef_idx     = r_coef_idx;
  assign bus.o_tap_first    = r_tap_first;
  assign bus.o_tap_last     = r_tap_last;
  assign bus.o_busy         = r_busy;
  assign bus.o_overrun      = r_overrun;

endmodule
`default_nettype wire
